uart_tx: RTL and testbench

UART transmitter: the transmit-side counterpart of the UART receive path. It accepts a parallel word through a valid/busy handshake and serialises it on `TX_OUT` as one frame:

- start bit
- `DATA_WIDTH` data bits, LSB first
- optional even/odd parity bit
- one stop bit

Bit timing comes from an internal divider clocked by `CLK` and set by `Prescale`, so TX and RX share the same clock and prescale settings.

---
 rtl/uart_tx.sv | 117 +++++++++++
 tb/tb_uart_tx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: serialises a shadowed parallel word as
// start / DATA_WIDTH data bits LSB first / optional parity / stop.
// Bit timing comes from an edge counter reloaded from the latched prescale.
module uart_tx #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic [5:0]            Prescale,
   output logic                  TX_OUT,
   output logic                  Busy
);

   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                state;
   logic [5:0]            edge_cnt;
   logic [5:0]            sh_pres;
   logic [5:0]            last_edge;
   logic [BW-1:0]         bit_cnt;
   logic [BW-1:0]         bit_nxt;
   logic [DATA_WIDTH-1:0] sh_data;
   logic                  sh_par_en;
   logic                  sh_par_typ;
   logic                  bit_done;
   logic                  par_bit;

   // A latched prescale of 0 behaves as 1, so the last edge is 0 in both cases.
   assign last_edge = (sh_pres == 6'd0) ? 6'd0 : sh_pres - 6'd1;
   assign bit_done  = (edge_cnt == last_edge);
   assign bit_nxt   = bit_cnt + BW'(1);
   // Parity always comes from the shadow word, never the live input.
   assign par_bit   = sh_par_typ ? ~^sh_data : ^sh_data;

   // Frame FSM; TX_OUT/Busy are loaded with the value of the state being entered.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= IDLE;
         edge_cnt   <= 6'd0;
         bit_cnt    <= '0;
         sh_data    <= '0;
         sh_par_en  <= 1'b0;
         sh_par_typ <= 1'b0;
         sh_pres    <= 6'd0;
         TX_OUT     <= 1'b1;
         Busy       <= 1'b0;
      end else begin
         if (state != IDLE)
            edge_cnt <= bit_done ? 6'd0 : edge_cnt + 6'd1;
         case (state)
            IDLE: begin
               TX_OUT   <= 1'b1;
               Busy     <= 1'b0;
               edge_cnt <= 6'd0;
               bit_cnt  <= '0;
               if (Data_Valid) begin
                  sh_data    <= P_DATA;
                  sh_par_en  <= PAR_EN;
                  sh_par_typ <= PAR_TYP;
                  sh_pres    <= Prescale;
                  state      <= START;
                  TX_OUT     <= 1'b0;
                  Busy       <= 1'b1;
               end
            end
            START: begin
               if (bit_done) begin
                  state  <= DATA;
                  TX_OUT <= sh_data[0];
               end
            end
            DATA: begin
               if (bit_done) begin
                  if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                     bit_cnt <= '0;
                     if (sh_par_en) begin
                        state  <= PARITY;
                        TX_OUT <= par_bit;
                     end else begin
                        state  <= STOP;
                        TX_OUT <= 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_nxt;
                     TX_OUT  <= sh_data[bit_nxt];
                  end
               end
            end
            PARITY: begin
               if (bit_done) begin
                  state  <= STOP;
                  TX_OUT <= 1'b1;
               end
            end
            STOP: begin
               if (bit_done) begin
                  state  <= IDLE;
                  TX_OUT <= 1'b1;
                  Busy   <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               TX_OUT <= 1'b1;
               Busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a per-cycle line model built from frame rules, checked
// every cycle, plus directed frames with hand-written bit patterns.
module tb_uart_tx;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [7:0] P_DATA = 8'h00;
   logic       Data_Valid = 1'b0;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic [5:0] Prescale = 6'd1;
   logic       TX_OUT;
   logic       Busy;

   int checks = 0;
   int errors = 0;

   uart_tx #(.DATA_WIDTH(8)) dut (
      .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
      .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .Prescale(Prescale),
      .TX_OUT(TX_OUT), .Busy(Busy)
   );

   always #5 CLK = ~CLK;

   // Model: queue of expected line levels, one entry per cycle of the frame.
   logic q[$];
   int   last_len = 0;

   always @(posedge CLK or posedge RST) begin
      int         mp;
      int         nb;
      logic [15:0] fb;
      if (RST) begin
         q.delete();
      end else if (q.size() != 0) begin
         q.delete(0);
      end else if (Data_Valid) begin
         mp = (Prescale == 6'd0) ? 1 : int'(Prescale);
         fb = '0;
         fb[0] = 1'b0;
         for (int i = 0; i < 8; i++) fb[1+i] = P_DATA[i];
         nb = 9;
         if (PAR_EN) begin
            fb[nb] = (($countones(P_DATA) % 2) == 1) ^ PAR_TYP;
            nb++;
         end
         fb[nb] = 1'b1;
         nb++;
         for (int b = 0; b < nb; b++)
            for (int c = 0; c < mp; c++) q.push_back(fb[b]);
         last_len <= nb * mp;
      end
   end

   // Every cycle: DUT outputs must match the model.
   always @(negedge CLK) begin
      logic et, eb;
      et = (q.size() != 0) ? q[0] : 1'b1;
      eb = (q.size() != 0);
      checks++;
      if (TX_OUT !== et || Busy !== eb) begin
         errors++;
         $display("FAIL model t=%0t tx=%b busy=%b want tx=%b busy=%b", $time, TX_OUT, Busy, et, eb);
      end
   end

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", name, got, exp);
      end
   endtask

   logic log_tx [0:4095];

   // Wait (bounded) for Busy, then record the line while Busy is high.
   // mode 1 tampers with inputs mid-frame; mode 2 changes P_DATA mid-frame.
   task automatic collect(input int mode, output int wait_c, output int busy_c);
      wait_c = 0;
      while (!Busy && wait_c < 200) begin
         @(negedge CLK);
         wait_c++;
      end
      busy_c = 0;
      while (Busy && busy_c < 4000) begin
         log_tx[busy_c] = TX_OUT;
         if (mode == 1 && busy_c == 40) begin
            P_DATA = 8'hFF; PAR_EN = 1'b1; PAR_TYP = 1'b1; Prescale = 6'd4;
            Data_Valid = 1'b1;
         end
         if (mode == 1 && busy_c == 41) Data_Valid = 1'b0;
         if (mode == 2 && busy_c == 10) P_DATA = 8'hFF;
         busy_c++;
         @(negedge CLK);
      end
   endtask

   task automatic chk_bits(input string name, input int p, input int nbits, input logic [15:0] exp);
      logic [15:0] got;
      got = '0;
      for (int i = 0; i < nbits; i++) got[i] = log_tx[i*p];
      chk(name, int'(got), int'(exp));
   endtask

   task automatic run(input string name, input logic [7:0] d, input int p, input logic en,
                      input logic typ, input int mode, input int nbits, input logic [15:0] expb,
                      input int explen);
      int w, n, pe;
      @(negedge CLK);
      P_DATA = d; PAR_EN = en; PAR_TYP = typ; Prescale = 6'(p); Data_Valid = 1'b1;
      @(negedge CLK);
      Data_Valid = 1'b0;
      collect(mode, w, n);
      pe = (p == 0) ? 1 : p;
      chk({name, "_busy_len"}, n, explen);
      chk({name, "_model_len"}, last_len, explen);
      chk_bits({name, "_bits"}, pe, nbits, expb);
   endtask

   initial begin
      int w, n, cnt_b, cnt_t;
      repeat (3) @(negedge CLK);
      chk("reset_tx", int'(TX_OUT), 1);
      chk("reset_busy", int'(Busy), 0);
      RST = 1'b0;
      repeat (3) @(negedge CLK);

      run("even_a5", 8'hA5, 8, 1'b1, 1'b0, 0, 11, 16'b10101001010, 88);
      run("odd_a5",  8'hA5, 8, 1'b1, 1'b1, 0, 11, 16'b11101001010, 88);
      run("nopar_a5", 8'hA5, 8, 1'b0, 1'b0, 0, 10, 16'b1101001010, 80);
      run("p0_55", 8'h55, 0, 1'b0, 1'b0, 0, 10, 16'b1010101010, 10);
      run("p1_55", 8'h55, 1, 1'b0, 1'b0, 0, 10, 16'b1010101010, 10);

      // Mid-frame input changes must not alter or re-trigger the frame.
      run("shadow_3c", 8'h3C, 16, 1'b0, 1'b0, 1, 10, 16'b1001111000, 160);
      cnt_b = 0;
      repeat (30) begin
         @(negedge CLK);
         if (Busy) cnt_b++;
      end
      chk("shadow_no_second", cnt_b, 0);

      // Back-to-back with Data_Valid held high.
      @(negedge CLK);
      P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8; Data_Valid = 1'b1;
      collect(2, w, n);
      chk("b2b_first_len", n, 80);
      chk_bits("b2b_first_bits", 8, 10, 16'b1000000000);
      chk("b2b_gap_tx", int'(TX_OUT), 1);
      collect(0, w, n);
      Data_Valid = 1'b0;
      chk("b2b_gap_cycles", w, 1);
      chk("b2b_second_len", n, 80);
      chk_bits("b2b_second_bits", 8, 10, 16'b1111111110);
      repeat (5) @(negedge CLK);

      // Asynchronous reset in the middle of the data bits.
      @(negedge CLK);
      P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; Prescale = 6'd8; Data_Valid = 1'b1;
      @(negedge CLK);
      Data_Valid = 1'b0;
      repeat (20) @(negedge CLK);
      chk("pre_reset_busy", int'(Busy), 1);
      #2 RST = 1'b1;
      #1;
      chk("async_reset_tx", int'(TX_OUT), 1);
      chk("async_reset_busy", int'(Busy), 0);
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      cnt_b = 0; cnt_t = 0;
      repeat (20) begin
         @(negedge CLK);
         if (Busy) cnt_b++;
         if (TX_OUT) cnt_t++;
      end
      chk("post_reset_busy", cnt_b, 0);
      chk("post_reset_idle", cnt_t, 20);

      // Randomized traffic, checked cycle by cycle against the model.
      for (int k = 0; k < 3000; k++) begin
         @(negedge CLK);
         Data_Valid = ($urandom_range(0, 3) == 0);
         P_DATA     = 8'($urandom);
         PAR_EN     = 1'($urandom);
         PAR_TYP    = 1'($urandom);
         Prescale   = 6'($urandom_range(0, 5));
      end
      Data_Valid = 1'b0;
      repeat (100) @(negedge CLK);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
